// File: rtl/spi_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_shift_ctrl                                               |
// | Description : Mode-0 SPI shift controller. Accepts a parallel word over    |
// |               valid/ready, shifts it out MSB-first on mosi while shifting  |
// |               miso into a receive register; programmable sclk divider.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_shift_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [WIDTH-1:0]     tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 abort,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]     rx_shift_q, rx_shift_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 mosi_q, mosi_d;
  logic [WIDTH-1:0]     rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tick;

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    // Half-period timer: tick marks the last clk of each sclk half-period;
    // wrapping to zero on tick also clears it on every state change.
    tick       = (div_cnt_q == div_q);
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_WIDTH'(1);

    if (state_q != IDLE && abort) begin
      // Cancel: drop the partial word, leave rx_data untouched.
      state_d   = IDLE;
      sclk_d    = 1'b0;
      cs_n_d    = 1'b1;
      div_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          div_cnt_d = '0;
          if (tx_valid) begin
            state_d    = SETUP;
            tx_shift_d = tx_data;
            rx_shift_d = '0;
            div_d      = clk_div;
            bit_cnt_d  = '0;
            cs_n_d     = 1'b0;
            sclk_d     = 1'b0;
          end
        end
        SETUP: begin
          // First rising edge: MSB has been on mosi for one half-period.
          if (tick) begin
            rx_shift_d = {rx_shift_q[WIDTH-2:0], miso};
            sclk_d     = 1'b1;
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (sclk_q) begin
              // Falling edge: present the next bit, or finish after the last.
              sclk_d = 1'b0;
              if (bit_cnt_q == LAST_BIT) begin
                state_d = DONE;
              end else begin
                bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                tx_shift_d = tx_shift_q << 1;
              end
            end else begin
              // Rising edge: sample the peripheral's bit.
              sclk_d     = 1'b1;
              rx_shift_d = {rx_shift_q[WIDTH-2:0], miso};
            end
          end
        end
        DONE: begin
          // Hold cs_n low one more half-period before releasing the slave.
          if (tick) begin
            state_d    = IDLE;
            cs_n_d     = 1'b1;
            sclk_d     = 1'b0;
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // mosi always reflects the MSB of the shift register while selected.
    mosi_d = (state_d == IDLE) ? 1'b0 : tx_shift_d[WIDTH-1];
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_shift_ctrl                                            |
// | Description : Self-checking bench for spi_shift_ctrl: transaction-level    |
// |               model compared every cycle plus directed literal checks.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_shift_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [7:0]   clk_div = '0;
  logic         abort = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;

  always #5 clk = ~clk;

  spi_shift_ctrl #(.WIDTH(W), .DIV_WIDTH(8)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .clk_div  (clk_div),
    .abort    (abort),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Peripheral stand-in: presents pat MSB-first, advancing after each sclk fall.
  logic [W-1:0] pat = '0;
  int           fall_n = 0;
  logic         sclk_seen = 1'b0;

  always @(negedge clk) begin
    if (cs_n !== 1'b0) fall_n <= 0;
    else if (sclk_seen && !sclk) fall_n <= fall_n + 1;
    sclk_seen <= sclk;
  end

  assign miso = (fall_n < W) ? pat[W-1-fall_n] : 1'b0;

  // Transaction model: a transfer lasts (2W+1) half-periods after the accept
  // edge; phase p = t/H, sclk high on odd phases, mosi carries bit W-1-p/2.
  logic         m_act;
  int           m_t;
  int           m_h;
  logic [W-1:0] m_data;
  logic [W-1:0] m_pat;
  logic [W-1:0] m_rx;
  logic         m_rxv;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_act  <= 1'b0;
      m_t    <= 0;
      m_h    <= 1;
      m_data <= '0;
      m_pat  <= '0;
      m_rx   <= '0;
      m_rxv  <= 1'b0;
    end else begin
      m_rxv <= 1'b0;
      if (m_act) begin
        if (abort) m_act <= 1'b0;
        else if (m_t + 1 == (2*W + 1) * m_h) begin
          m_act <= 1'b0;
          m_rxv <= 1'b1;
          m_rx  <= m_pat;
        end else m_t <= m_t + 1;
      end else if (tx_valid) begin
        m_act  <= 1'b1;
        m_t    <= 0;
        m_h    <= int'(clk_div) + 1;
        m_data <= tx_data;
        m_pat  <= pat;
      end
    end
  end

  bit mon_en = 1'b0;
  int cmp_p;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mon_en && clr_n) begin
      cmp_p = m_t / m_h;
      chk("tx_ready", {31'd0, tx_ready}, {31'd0, !m_act});
      chk("busy", {31'd0, busy}, {31'd0, m_act});
      chk("cs_n", {31'd0, cs_n}, {31'd0, !m_act});
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, m_rxv});
      chk("rx_data", 32'(rx_data), 32'(m_rx));
      chk("sclk", {31'd0, sclk}, {31'd0, m_act && (cmp_p % 2 == 1)});
      if (!m_act) chk("mosi_idle", {31'd0, mosi}, 32'd0);
      else if (cmp_p < 2*W) chk("mosi", {31'd0, mosi}, {31'd0, m_data[W-1-cmp_p/2]});
    end
  end

  // One transfer from an idle controller; measures latency, cs_n low time,
  // sclk rising edges and the mosi bits seen at those edges.
  task automatic run_xfer(input logic [W-1:0] d, input logic [7:0] div,
                          input logic [W-1:0] p, input bit chg,
                          output int k, output int csl, output int rises,
                          output logic [W-1:0] mw);
    logic prev;
    bit   done;
    pat = p;
    @(negedge clk);
    tx_data  = d;
    clk_div  = div;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (chg) begin
      tx_data = '0;
      clk_div = 8'h07;
    end
    k = 0; csl = 0; rises = 0; mw = '0; prev = 1'b0; done = 1'b0;
    while (!done && k < 1000) begin
      if (rx_valid) done = 1'b1;
      else begin
        if (!cs_n) csl++;
        if (sclk && !prev) begin
          rises++;
          mw = {mw[W-2:0], mosi};
        end
        prev = sclk;
        @(negedge clk);
        k++;
      end
    end
    chk("xfer_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int k, csl, rises, k1, k2;
    logic [W-1:0] mw;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    clr_n  = 1'b1;
    mon_en = 1'b1;

    // Basic transfer, H=2: 17 half-periods of 2 cycles each
    run_xfer(8'hA5, 8'd1, 8'h3C, 1'b0, k, csl, rises, mw);
    chk("t1_latency", k, 34);
    chk("t1_cs_low", csl, 34);
    chk("t1_rises", rises, 8);
    chk("t1_mosi", 32'(mw), 32'hA5);
    chk("t1_rx_data", 32'(rx_data), 32'h3C);
    @(negedge clk);
    chk("t1_rxv_pulse", {31'd0, rx_valid}, 32'd0);

    // Abort in the 4th sclk high phase (t=14 with H=2)
    pat = 8'hFF;
    @(negedge clk);
    tx_data = 8'h5A; clk_div = 8'd1; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 200 && !(m_act && m_t == 14); i++) @(negedge clk);
    chk("abort_reached", {31'd0, (m_act && m_t == 14)}, 32'd1);
    chk("abort_sclk_hi", {31'd0, sclk}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cs_n", {31'd0, cs_n}, 32'd1);
    chk("abort_sclk", {31'd0, sclk}, 32'd0);
    chk("abort_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'h3C);
    repeat (4) @(negedge clk);

    // Inputs changed right after acceptance must not matter
    run_xfer(8'hA5, 8'd1, 8'h96, 1'b1, k, csl, rises, mw);
    chk("t6_latency", k, 34);
    chk("t6_cs_low", csl, 34);
    chk("t6_rises", rises, 8);
    chk("t6_mosi", 32'(mw), 32'hA5);
    chk("t6_rx_data", 32'(rx_data), 32'h96);

    // H=1: sclk = clk/2
    run_xfer(8'hFF, 8'd0, 8'h00, 1'b0, k, csl, rises, mw);
    chk("t2_latency", k, 17);
    chk("t2_rises", rises, 8);
    chk("t2_mosi", 32'(mw), 32'hFF);
    chk("t2_rx_data", 32'(rx_data), 32'h00);

    // Back-to-back with tx_valid held high
    pat = 8'hC3;
    @(negedge clk);
    tx_data = 8'h12; clk_div = 8'd1; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h34;
    k1 = 0;
    while (!rx_valid && k1 < 1000) begin
      @(negedge clk);
      k1++;
    end
    chk("b2b_first_latency", k1, 34);
    chk("b2b_ready_with_rxv", {31'd0, tx_ready}, 32'd1);
    chk("b2b_cs_gap", {31'd0, cs_n}, 32'd1);
    chk("b2b_rx1", 32'(rx_data), 32'hC3);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("b2b_cs_relow", {31'd0, cs_n}, 32'd0);
    chk("b2b_busy2", {31'd0, busy}, 32'd1);
    k2 = 0;
    while (!rx_valid && k2 < 1000) begin
      @(negedge clk);
      k2++;
    end
    chk("b2b_gap_total", k2 + 1, 35);
    chk("b2b_rx2", 32'(rx_data), 32'hC3);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of SHIFT
    pat = 8'hFF;
    tx_data = 8'hA5; clk_div = 8'd1; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 200 && !(m_act && m_t == 10); i++) @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk("arst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("arst_sclk", {31'd0, sclk}, 32'd0);
    chk("arst_rx_data", 32'(rx_data), 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rx_valid", {31'd0, rx_valid}, 32'd0);
    @(negedge clk);
    #2;
    clr_n = 1'b1;
    @(negedge clk);

    // Normal transfer after reset, H=3
    run_xfer(8'h3C, 8'd2, 8'hA5, 1'b0, k, csl, rises, mw);
    chk("t7_latency", k, 51);
    chk("t7_rises", rises, 8);
    chk("t7_mosi", 32'(mw), 32'h3C);
    chk("t7_rx_data", 32'(rx_data), 32'hA5);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
